// File: rtl/sif_resp.sv
// SIF responder: XA register bank with latency-1 reads, plus a WA forward FIFO of accepted writes.
// Optional feature macro SIF_STATUS_EN: maps a read-only status word at 16'hFFFF (a write there clears ovf).
module sif_resp #(
  parameter int DEPTH  = 16,
  parameter int QDEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] xa_addr,
  input  logic [15:0] xa_data_wr,
  input  logic        xa_wr_s,
  input  logic        xa_rd_s,
  output logic [15:0] xa_data_rd,
  output logic        xa_rd_vld,
  output logic        xa_busy,
  output logic [15:0] wa_addr,
  output logic [15:0] wa_data_wr,
  output logic        wa_vld,
  input  logic        wa_wr_s,
  output logic        ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [16:0]   DEPTH_LIM = 17'(DEPTH);
  localparam logic [CW-1:0] QFULL     = CW'(QDEPTH);

  logic [15:0]   reg_bank [DEPTH];
  logic [15:0]   fifo_addr [QDEPTH];
  logic [15:0]   fifo_data [QDEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          ovf_reg, ovf_next;
  logic [15:0]   rd_data_reg, rd_data_next;
  logic          rd_vld_reg;

  logic          in_range;
  logic [AW-1:0] reg_idx;
  logic          wr_hit;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          push_ok;
  logic          push_drop;
  logic          stat_hit;
  logic          ovf_clr;
  logic [15:0]   status_word;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  assign in_range   = ({1'b0, xa_addr} < DEPTH_LIM);
  assign reg_idx    = xa_addr[AW-1:0];
  assign wr_hit     = xa_wr_s && in_range;

  assign fifo_full  = (count_reg == QFULL);
  assign fifo_empty = (count_reg == '0);
  assign pop        = wa_wr_s && !fifo_empty;

  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok    = wr_hit && (!fifo_full || pop);
  assign push_drop  = wr_hit && fifo_full && !pop;

`ifdef SIF_STATUS_EN
  assign stat_hit    = (xa_addr == 16'hFFFF);
  assign ovf_clr     = xa_wr_s && stat_hit;
  assign status_word = {ovf_reg, fifo_full, !fifo_empty, 9'b0, 4'(count_reg)};
`else
  assign stat_hit    = 1'b0;
  assign ovf_clr     = 1'b0;
  assign status_word = 16'h0000;
`endif

  // ---------------------------------------------------------------------------
  // Register bank: one resettable 16-bit register per address
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        reg_bank[gi] <= '0;
      end else if (wr_hit && (reg_idx == AW'(gi))) begin
        reg_bank[gi] <= xa_data_wr;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path: sampled from pre-edge contents, so a same-cycle write is not seen
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_data_next = rd_data_reg;
    if (xa_rd_s) begin
      if (in_range) begin
        rd_data_next = reg_bank[reg_idx];
      end else if (stat_hit) begin
        rd_data_next = status_word;
      end else begin
        rd_data_next = 16'h0000;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_reg <= '0;
      rd_vld_reg  <= 1'b0;
    end else begin
      rd_data_reg <= rd_data_next;
      rd_vld_reg  <= xa_rd_s;
    end
  end

  // ---------------------------------------------------------------------------
  // WA forward FIFO
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    ovf_next    = ovf_reg;

    if (push_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end

    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase

    if (ovf_clr) begin
      ovf_next = 1'b0;
    end else if (push_drop) begin
      ovf_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      ovf_reg    <= ovf_next;
    end
  end

  // Storage needs no reset; the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr_reg] <= xa_addr;
      fifo_data[wr_ptr_reg] <= xa_data_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign xa_data_rd = rd_data_reg;
  assign xa_rd_vld  = rd_vld_reg;
  assign xa_busy    = fifo_full;
  assign wa_vld     = !fifo_empty;
  assign wa_addr    = fifo_empty ? 16'h0000 : fifo_addr[rd_ptr_reg];
  assign wa_data_wr = fifo_empty ? 16'h0000 : fifo_data[rd_ptr_reg];
  assign ovf        = ovf_reg;

endmodule

// File: tb/tb_sif_resp.sv
// Self-checking bench for sif_resp: scoreboard of expected read data and forwarded WA records.
module tb_sif_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] xa_addr;
  logic [15:0] xa_data_wr;
  logic        xa_wr_s;
  logic        xa_rd_s;
  logic [15:0] xa_data_rd;
  logic        xa_rd_vld;
  logic        xa_busy;
  logic [15:0] wa_addr;
  logic [15:0] wa_data_wr;
  logic        wa_vld;
  logic        wa_wr_s;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_regs [16];
  logic        m_ovf;
  logic [15:0] rd_q [$];
  logic [31:0] wa_q [$];

  always #5 clk = ~clk;

  sif_resp dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_data_rd (xa_data_rd),
    .xa_rd_vld  (xa_rd_vld),
    .xa_busy    (xa_busy),
    .wa_addr    (wa_addr),
    .wa_data_wr (wa_data_wr),
    .wa_vld     (wa_vld),
    .wa_wr_s    (wa_wr_s),
    .ovf        (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: update the model with pre-edge state, then check after the edge.
  task automatic do_cycle(input logic rst, input logic rd, input logic wr, input logic pp,
                          input logic [15:0] addr, input logic [15:0] data);
    logic        exp_rdv;
    logic [15:0] stat;
    @(negedge clk);
    rst_n      = rst;
    xa_rd_s    = rd;
    xa_wr_s    = wr;
    wa_wr_s    = pp;
    xa_addr    = addr;
    xa_data_wr = data;
    stat = {m_ovf, wa_q.size() == 4, wa_q.size() != 0, 9'b0, 4'(wa_q.size())};
    if (!rst) begin
      exp_rdv = 1'b0;
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_ovf = 1'b0;
      rd_q.delete();
      wa_q.delete();
    end else begin
      exp_rdv = rd;
      if (rd) begin
        if (addr < 16) rd_q.push_back(m_regs[addr[3:0]]);
`ifdef SIF_STATUS_EN
        else if (addr == 16'hFFFF) rd_q.push_back(stat);
`endif
        else rd_q.push_back(16'h0000);
      end
      if (pp && wa_q.size() > 0) void'(wa_q.pop_front());
      if (wr) begin
        if (addr < 16) begin
          m_regs[addr[3:0]] = data;
          if (wa_q.size() < 4) wa_q.push_back({addr, data});
          else m_ovf = 1'b1;
        end
`ifdef SIF_STATUS_EN
        else if (addr == 16'hFFFF) m_ovf = 1'b0;
`endif
      end
    end
    @(posedge clk);
    #1;
    $display("cyc rst_n=%0b rd=%0b wr=%0b pop=%0b addr=%h data=%h -> rd_vld=%0b rd=%h wa_vld=%0b wa=%h/%h busy=%0b ovf=%0b",
             rst, rd, wr, pp, addr, data, xa_rd_vld, xa_data_rd, wa_vld, wa_addr, wa_data_wr, xa_busy, ovf);
    check("rd_vld", {31'b0, xa_rd_vld}, {31'b0, exp_rdv});
    if (!rst) begin
      check("rst_rd_data", {16'b0, xa_data_rd}, 32'h0);
      check("rst_wa_addr", {16'b0, wa_addr}, 32'h0);
      check("rst_wa_data", {16'b0, wa_data_wr}, 32'h0);
    end else if (xa_rd_vld) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'h1, 32'h0);
      else check("rd_data", {16'b0, xa_data_rd}, {16'b0, rd_q.pop_front()});
    end
    check("busy", {31'b0, xa_busy}, {31'b0, wa_q.size() == 4});
    check("wa_vld", {31'b0, wa_vld}, {31'b0, wa_q.size() != 0});
    check("ovf", {31'b0, ovf}, {31'b0, m_ovf});
    if (wa_q.size() > 0) check("wa_head", {wa_addr, wa_data_wr}, wa_q[0]);
  endtask

  initial begin
    rst_n = 1'b0; xa_rd_s = 1'b0; xa_wr_s = 1'b0; wa_wr_s = 1'b0;
    xa_addr = '0; xa_data_wr = '0; m_ovf = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    // Reset held two cycles, then read an untouched register
    do_cycle(0, 0, 0, 0, 16'h0, 16'h0);
    do_cycle(0, 0, 0, 0, 16'h0, 16'h0);
    do_cycle(1, 1, 0, 0, 16'd3, 16'h0);
    do_cycle(1, 0, 0, 0, 16'd0, 16'h0);

    // Basic write / read / forward
    do_cycle(1, 0, 1, 0, 16'd5, 16'hA5A5);
    do_cycle(1, 1, 0, 0, 16'd5, 16'h0);
    do_cycle(1, 0, 0, 1, 16'd0, 16'h0);

    // Fill FIFO, overflow on the fifth write, register still updated
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 1, 0, 16'(i), 16'(i + 1));
    do_cycle(1, 1, 0, 0, 16'd4, 16'h0);
    // Push and pop together while full: accepted, ovf unchanged
    do_cycle(1, 0, 1, 1, 16'd7, 16'h7777);
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 0, 1, 16'd0, 16'h0);
    do_cycle(1, 0, 0, 1, 16'd0, 16'h0);

    // Read-before-write in the same cycle
    do_cycle(1, 0, 1, 0, 16'd2, 16'h1111);
    do_cycle(1, 1, 1, 0, 16'd2, 16'h2222);
    do_cycle(1, 1, 0, 1, 16'd2, 16'h0);
    do_cycle(1, 0, 0, 1, 16'd0, 16'h0);

    // Out-of-range and status addresses
    do_cycle(1, 0, 1, 0, 16'd16, 16'hBEEF);
    do_cycle(1, 1, 0, 0, 16'd16, 16'h0);
    do_cycle(1, 1, 0, 0, 16'hFFFF, 16'h0);

    // Overflow again, then status read and clear via 16'hFFFF
    for (int i = 0; i < 5; i++) do_cycle(1, 0, 1, 0, 16'(8 + i), 16'(16'hC000 + i));
    do_cycle(1, 1, 0, 0, 16'hFFFF, 16'h0);
    do_cycle(1, 0, 1, 0, 16'hFFFF, 16'h0);
    do_cycle(1, 1, 0, 0, 16'hFFFF, 16'h0);

    // Reset mid-operation with a read pending in the same cycle
    do_cycle(0, 1, 1, 0, 16'd1, 16'h1234);
    do_cycle(1, 1, 0, 0, 16'd8, 16'h0);

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom_range(0, 17));
      do_cycle(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 2) == 0), a, 16'($urandom));
    end
    do_cycle(1, 0, 0, 0, 16'h0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
